// File: rtl/suspend_pkg.sv
// Shared types and helpers for the suspend-sync handshake controller.
package suspend_pkg;

  localparam int SUSP_MAX_REQ = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    SETTLE  = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } susp_state_e;

  // Ceiling log2; used to size counters that must hold the value 'value-1'.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/suspend_sync_ctrl_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain; only the last stage is safe to consume.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/suspend_sync_ctrl.sv
// Suspend handshake sequencer: quiesces clients, settles, acknowledges the
// suspend-sync primitive, and releases the clients when the request is withdrawn.
module suspend_sync_ctrl
  import suspend_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SETTLE_CYC  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SREQ,
  output logic               SACK,
  input  logic [NUM_REQ-1:0] CLIENT_EN,
  output logic [NUM_REQ-1:0] QUIESCE_REQ,
  input  logic [NUM_REQ-1:0] QUIESCE_ACK,
  output logic               SUSPENDED,
  output logic               TIMEOUT_ERR,
  input  logic               CLR_ERR,
  output logic [2:0]         STATE
);

  localparam int            TW         = clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] SETTLE_END = TW'(SETTLE_CYC);

  susp_state_e        r_state;
  susp_state_e        w_next;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] w_next_mask;
  logic [TW-1:0]      r_timer;
  logic               r_forced;
  logic               w_set_err;
  logic               w_sreq_s;
  logic               w_all_ack;
  logic               w_all_rel;
  logic               w_state_chg;
  logic               w_counting;
  logic               r_sack;
  logic               r_susp;
  logic               r_err;
  logic [NUM_REQ-1:0] r_qreq;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sreq_sync (
    .i_clk(CLK),
    .i_rst(RST),
    .i_d  (SREQ),
    .o_q  (w_sreq_s)
  );

  assign w_all_ack   = &(QUIESCE_ACK | ~r_mask);
  assign w_all_rel   = ~|(QUIESCE_ACK & r_mask);
  assign w_state_chg = (w_next != r_state);
  assign w_counting  = (r_state == DRAIN) || (r_state == SETTLE) || (r_state == RELEASE);

  // Next-state, mask and error-set decode; abort (sreq_s low) always wins.
  always_comb begin
    w_next      = r_state;
    w_next_mask = r_mask;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sreq_s) begin
          w_next      = DRAIN;
          w_next_mask = CLIENT_EN;
        end else begin
          w_next = IDLE;
        end
      end
      DRAIN: begin
        if (!w_sreq_s) begin
          w_next = RELEASE;
        end else if (w_all_ack) begin
          w_next = SETTLE;
        end else if (r_timer == TMO_LAST) begin
          w_next    = SETTLE;
          w_set_err = 1'b1;
        end else begin
          w_next = DRAIN;
        end
      end
      SETTLE: begin
        if (!w_sreq_s) begin
          w_next = RELEASE;
        end else if (!w_all_ack && !r_forced) begin
          w_next = DRAIN;
        end else if (r_timer == SETTLE_END) begin
          w_next = ACK;
        end else begin
          w_next = SETTLE;
        end
      end
      ACK: begin
        if (!w_sreq_s) begin
          w_next = RELEASE;
        end else begin
          w_next = ACK;
        end
      end
      RELEASE: begin
        if (w_all_rel) begin
          w_next = IDLE;
        end else if (r_timer == TMO_LAST) begin
          w_next    = IDLE;
          w_set_err = 1'b1;
        end else begin
          w_next = RELEASE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (w_next == IDLE) begin
      w_next_mask = '0;
    end else begin
      w_next_mask = w_next_mask;
    end
  end

  // State, latched mask, per-state timer and forced-settle marker.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_timer  <= '0;
      r_forced <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mask  <= w_next_mask;
      if (w_state_chg) begin
        r_timer  <= '0;
        r_forced <= w_set_err && (w_next == SETTLE);
      end else if (w_counting) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= r_timer;
      end
    end
  end

  // Outputs are decoded from the next state so they align with STATE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sack <= 1'b0;
      r_susp <= 1'b0;
      r_qreq <= '0;
    end else begin
      r_sack <= (w_next == ACK);
      r_susp <= (w_next == ACK);
      if ((w_next == DRAIN) || (w_next == SETTLE) || (w_next == ACK)) begin
        r_qreq <= w_next_mask;
      end else begin
        r_qreq <= '0;
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end else if (CLR_ERR) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign SACK        = r_sack;
  assign SUSPENDED   = r_susp;
  assign QUIESCE_REQ = r_qreq;
  assign TIMEOUT_ERR = r_err;
  assign STATE       = r_state;

endmodule

// File: tb/tb_suspend_sync_ctrl.sv
// Directed self-checking bench for suspend_sync_ctrl (SYNC=2, SETTLE=8, TIMEOUT=16).
module tb_suspend_sync_ctrl;

  logic       CLK;
  logic       RST;
  logic       SREQ;
  logic       SACK;
  logic [3:0] CLIENT_EN;
  logic [3:0] QUIESCE_REQ;
  logic [3:0] QUIESCE_ACK;
  logic       SUSPENDED;
  logic       TIMEOUT_ERR;
  logic       CLR_ERR;
  logic [2:0] STATE;

  int total = 0;
  int bad   = 0;

  suspend_sync_ctrl #(
    .NUM_REQ    (4),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(16),
    .SETTLE_CYC (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SREQ       (SREQ),
    .SACK       (SACK),
    .CLIENT_EN  (CLIENT_EN),
    .QUIESCE_REQ(QUIESCE_REQ),
    .QUIESCE_ACK(QUIESCE_ACK),
    .SUSPENDED  (SUSPENDED),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .CLR_ERR    (CLR_ERR),
    .STATE      (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; SREQ = 1'b0; CLIENT_EN = 4'h0; QUIESCE_ACK = 4'h0; CLR_ERR = 1'b0;
    tick(2);
    chk("rst_state", STATE, 32'd0);
    chk("rst_sack", SACK, 32'd0);
    chk("rst_qreq", QUIESCE_REQ, 32'd0);
    chk("rst_susp", SUSPENDED, 32'd0);
    chk("rst_err", TIMEOUT_ERR, 32'd0);
    RST = 1'b0;
    tick(1);

    // 1: basic handshake, clients ack 5 cycles after QUIESCE_REQ
    CLIENT_EN = 4'hF; SREQ = 1'b1;
    tick(2);
    chk("t1_idle_state", STATE, 32'd0);
    chk("t1_idle_qreq", QUIESCE_REQ, 32'd0);
    tick(1);
    chk("t1_drain_state", STATE, 32'd1);
    chk("t1_drain_qreq", QUIESCE_REQ, 32'hF);
    tick(4);
    chk("t1_still_drain", STATE, 32'd1);
    QUIESCE_ACK = 4'hF;
    tick(1);
    chk("t1_settle_state", STATE, 32'd2);
    tick(8);
    chk("t1_sack_early", SACK, 32'd0);
    tick(1);
    chk("t1_sack", SACK, 32'd1);
    chk("t1_susp", SUSPENDED, 32'd1);
    chk("t1_ack_state", STATE, 32'd3);
    chk("t1_err", TIMEOUT_ERR, 32'd0);
    SREQ = 1'b0;
    tick(2);
    chk("t1_sack_hold", SACK, 32'd1);
    tick(1);
    chk("t1_rel_sack", SACK, 32'd0);
    chk("t1_rel_susp", SUSPENDED, 32'd0);
    chk("t1_rel_qreq", QUIESCE_REQ, 32'd0);
    chk("t1_rel_state", STATE, 32'd4);
    tick(2);
    chk("t1_rel_wait", STATE, 32'd4);
    QUIESCE_ACK = 4'h0;
    tick(1);
    chk("t1_idle_back", STATE, 32'd0);

    // 2: masked clients 1 and 3 never ack; minimum SACK latency of 13 edges
    CLIENT_EN = 4'b0101; QUIESCE_ACK = 4'b0101; SREQ = 1'b1;
    tick(3);
    chk("t2_drain_state", STATE, 32'd1);
    chk("t2_qreq", QUIESCE_REQ, 32'h5);
    CLIENT_EN = 4'hF;
    tick(1);
    chk("t2_settle_state", STATE, 32'd2);
    tick(8);
    chk("t2_sack_early", SACK, 32'd0);
    tick(1);
    chk("t2_sack", SACK, 32'd1);
    chk("t2_qreq_held", QUIESCE_REQ, 32'h5);
    chk("t2_err", TIMEOUT_ERR, 32'd0);
    SREQ = 1'b0;
    tick(3);
    chk("t2_rel_state", STATE, 32'd4);
    QUIESCE_ACK = 4'h0;
    tick(1);
    chk("t2_idle", STATE, 32'd0);

    // 3: client 2 never acks -> drain timeout, forced settle, release timeout
    CLIENT_EN = 4'hF; QUIESCE_ACK = 4'b1011; SREQ = 1'b1;
    tick(3);
    chk("t3_drain_state", STATE, 32'd1);
    tick(15);
    chk("t3_pre_tmo_state", STATE, 32'd1);
    chk("t3_pre_tmo_err", TIMEOUT_ERR, 32'd0);
    tick(1);
    chk("t3_tmo_state", STATE, 32'd2);
    chk("t3_tmo_err", TIMEOUT_ERR, 32'd1);
    tick(8);
    chk("t3_forced_settle", STATE, 32'd2);
    chk("t3_sack_early", SACK, 32'd0);
    tick(1);
    chk("t3_sack", SACK, 32'd1);
    chk("t3_err_sticky", TIMEOUT_ERR, 32'd1);
    CLR_ERR = 1'b1;
    tick(1);
    chk("t3_err_clr", TIMEOUT_ERR, 32'd0);
    CLR_ERR = 1'b0; SREQ = 1'b0;
    tick(3);
    chk("t3_rel_state", STATE, 32'd4);
    tick(15);
    chk("t3_rel_wait", STATE, 32'd4);
    chk("t3_rel_err0", TIMEOUT_ERR, 32'd0);
    tick(1);
    chk("t3_rel_tmo_state", STATE, 32'd0);
    chk("t3_rel_tmo_err", TIMEOUT_ERR, 32'd1);
    CLR_ERR = 1'b1; QUIESCE_ACK = 4'h0;
    tick(1);
    chk("t3_err_clr2", TIMEOUT_ERR, 32'd0);
    CLR_ERR = 1'b0;

    // 4: abort during drain with two of four clients acked
    QUIESCE_ACK = 4'h0; SREQ = 1'b1;
    tick(3);
    chk("t4_drain_state", STATE, 32'd1);
    QUIESCE_ACK = 4'b0011;
    tick(2);
    chk("t4_drain_hold", STATE, 32'd1);
    chk("t4_sack_drain", SACK, 32'd0);
    SREQ = 1'b0;
    tick(2);
    chk("t4_sync_lag", STATE, 32'd1);
    tick(1);
    chk("t4_rel_state", STATE, 32'd4);
    chk("t4_rel_sack", SACK, 32'd0);
    QUIESCE_ACK = 4'h0;
    tick(1);
    chk("t4_idle", STATE, 32'd0);
    chk("t4_idle_sack", SACK, 32'd0);

    // 5: client 0 drops ack for one cycle during settle
    QUIESCE_ACK = 4'hF; SREQ = 1'b1;
    tick(3);
    chk("t5_drain_state", STATE, 32'd1);
    tick(1);
    chk("t5_settle_state", STATE, 32'd2);
    tick(2);
    QUIESCE_ACK = 4'b1110;
    tick(1);
    chk("t5_back_drain", STATE, 32'd1);
    QUIESCE_ACK = 4'hF;
    tick(1);
    chk("t5_resettle", STATE, 32'd2);
    tick(5);
    chk("t5_sack_delayed", SACK, 32'd0);
    tick(3);
    chk("t5_sack_early", SACK, 32'd0);
    tick(1);
    chk("t5_sack", SACK, 32'd1);

    // 6: asynchronous reset while suspended, SREQ kept high
    #3;
    RST = 1'b1;
    #1;
    chk("t6_async_sack", SACK, 32'd0);
    chk("t6_async_qreq", QUIESCE_REQ, 32'd0);
    chk("t6_async_state", STATE, 32'd0);
    chk("t6_async_susp", SUSPENDED, 32'd0);
    tick(1);
    RST = 1'b0;
    tick(2);
    chk("t6_sync_lag", STATE, 32'd0);
    tick(1);
    chk("t6_redrain", STATE, 32'd1);
    chk("t6_redrain_qreq", QUIESCE_REQ, 32'hF);
    SREQ = 1'b0; QUIESCE_ACK = 4'h0;
    tick(3);
    chk("t6_rel_state", STATE, 32'd4);
    tick(1);
    chk("t6_idle", STATE, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
